// File: rtl/jump_controller.sv
// Frame-stepped vertical-motion sequencer for the T-rex sprite: jump FSM,
// signed velocity and Y position, gravity integrated once per frame tick.
module jump_controller #(
  parameter int unsigned GROUND_Y   = 300,
  parameter int unsigned INIT_SPEED = 20,
  parameter int unsigned G          = 1,
  parameter int unsigned FAST_G     = 2,
  parameter int unsigned VW         = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 jump,
  input  logic                 duck,
  output logic [31:0]          Y,
  output logic signed [VW-1:0] velocity,
  output logic                 airborne,
  output logic                 landed,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    AIR    = 2'd1,
    LAND   = 2'd2
  } state_t;

  localparam logic signed [32:0]   GROUND_S = 33'(GROUND_Y);
  localparam logic signed [VW-1:0] LAUNCH_V = VW'(0) - VW'(INIT_SPEED);
  localparam logic signed [VW:0]   G_EXT    = (VW+1)'(G);
  localparam logic signed [VW:0]   FG_EXT   = (VW+1)'(FAST_G);
  localparam logic signed [VW:0]   VMAX_EXT = (VW+1)'(2**(VW-1) - 1);
  localparam logic signed [VW-1:0] VMAX_V   = VMAX_EXT[VW-1:0];

  state_t                 state_q;
  logic [31:0]            yPos_q;
  logic signed [VW-1:0]   vel_q;
  logic                   jump_q;
  logic                   pending_q;
  logic                   landed_q;
  logic                   airborne_q;

  logic                   jumpEdge_d;
  logic                   launch_d;
  logic signed [32:0]     yNext_d;
  logic signed [VW:0]     velSum_d;
  logic signed [VW-1:0]   velSat_d;

  // Candidate air-step values; one extra bit keeps the sums free of overflow.
  always_comb begin
    jumpEdge_d = jump & ~jump_q;
    launch_d   = pending_q | jumpEdge_d;
    yNext_d    = $signed({1'b0, yPos_q}) + 33'(vel_q);
    velSum_d   = (VW+1)'(vel_q) + G_EXT + (duck ? FG_EXT : '0);
    velSat_d   = (velSum_d > VMAX_EXT) ? VMAX_V : velSum_d[VW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= GROUND;
      yPos_q     <= 32'(GROUND_Y);
      vel_q      <= '0;
      jump_q     <= 1'b0;
      pending_q  <= 1'b0;
      landed_q   <= 1'b0;
      airborne_q <= 1'b0;
    end else begin
      jump_q   <= jump;
      landed_q <= 1'b0;
      if (frame_tick) begin
        unique case (state_q)
          GROUND, LAND: begin
            // LAND behaves like GROUND for launching, giving a one-frame jump buffer.
            if (launch_d) begin
              vel_q      <= LAUNCH_V;
              state_q    <= AIR;
              airborne_q <= 1'b1;
              pending_q  <= 1'b0;
            end else begin
              state_q <= GROUND;
            end
          end
          AIR: begin
            if (!yNext_d[32] && (yNext_d >= GROUND_S)) begin
              yPos_q     <= 32'(GROUND_Y);
              vel_q      <= '0;
              state_q    <= LAND;
              airborne_q <= 1'b0;
              landed_q   <= 1'b1;
            end else if (yNext_d[32]) begin
              yPos_q <= '0;
              vel_q  <= '0;
            end else begin
              yPos_q <= yNext_d[31:0];
              vel_q  <= velSat_d;
            end
          end
          default: begin
            state_q    <= GROUND;
            airborne_q <= 1'b0;
          end
        endcase
      end else if (jumpEdge_d && (state_q != AIR)) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign Y        = yPos_q;
  assign velocity = vel_q;
  assign airborne = airborne_q;
  assign landed   = landed_q;
  assign state    = state_q;

endmodule
